// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: requester count,
// default timing constants and the arbiter FSM state type.
package uart_pkg;

  localparam int NREQ               = 3;
  localparam int GAP_CYCLES_DEF     = 1250;
  localparam int TIMEOUT_CYCLES_DEF = 16384;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first pending channel found searching
// upward from ptr, wrapping modulo the requester count.
module rr_pick
  import uart_pkg::*;
(
  input  logic [NREQ-1:0] pending,
  input  logic [1:0]      ptr,
  output logic            any,
  output logic [1:0]      idx
);

  logic [1:0]      cand [NREQ];
  logic [NREQ-1:0] hit;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum       = {1'b0, ptr} + 3'(gi);
    assign cand[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    assign hit[gi]   = pending[cand[gi]];
  end

  assign any = |pending;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    idx = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Three-requester byte arbiter in front of a UART transmitter: holding
// registers, round-robin grant, launch/done handshake, timeout and gap.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic            enable,
  input  logic [2:0]      req_valid,
  input  logic [23:0]     req_data,
  output logic [2:0]      req_ready,
  output logic            tx_start,
  output logic [7:0]      tx_byte,
  input  logic            tx_done,
  output logic [1:0]      grant_id,
  output logic            busy,
  output logic            done_pulse,
  output logic            err_pulse
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [7:0]      hold_q [NREQ];
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      grant_q, grant_d;
  logic [TW-1:0]   to_q, to_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [NREQ-1:0] take;
  logic [NREQ-1:0] clr_mask;
  logic            pick_any;
  logic [1:0]      pick_idx;
  logic            done_w, err_w, finish_w;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_chan
    assign take[gi]      = req_valid[gi] & ~pending_q[gi];
    assign req_ready[gi] = ~pending_q[gi];
    assign clr_mask[gi]  = finish_w & (grant_q == 2'(gi));
  end

  rr_pick u_rr_pick (
    .pending (pending_q),
    .ptr     (rr_q),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  // A same-cycle tx_done wins over the timeout.
  assign done_w   = (state_q == ST_WAIT_DONE) & tx_done;
  assign err_w    = (state_q == ST_WAIT_DONE) & ~tx_done & (to_q == TW'(TIMEOUT_CYCLES - 1));
  assign finish_w = done_w | err_w;

  assign pending_d = (pending_q | take) & ~clr_mask;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    to_d    = to_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && pick_any) begin
          grant_d = pick_idx;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        to_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        to_d = to_q + 1'b1;
        if (finish_w) begin
          rr_d    = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      rr_q      <= 2'd0;
      grant_q   <= 2'd0;
      to_q      <= '0;
      gap_q     <= '0;
      for (int i = 0; i < NREQ; i++) hold_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      to_q      <= to_d;
      gap_q     <= gap_d;
      for (int i = 0; i < NREQ; i++) begin
        if (take[i]) hold_q[i] <= req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    if (state_q == ST_LAUNCH || state_q == ST_WAIT_DONE) begin
      case (grant_q)
        2'd0:    tx_byte = hold_q[0];
        2'd1:    tx_byte = hold_q[1];
        2'd2:    tx_byte = hold_q[2];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign tx_start   = (state_q == ST_LAUNCH);
  assign grant_id   = grant_q;
  assign busy       = (state_q != ST_IDLE);
  assign done_pulse = done_w;
  assign err_pulse  = err_w;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with GAP_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        nRst;
  logic        enable;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        done_pulse;
  logic        err_pulse;

  int checks = 0;
  int errors = 0;

  uart_tx_arb #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .busy       (busy),
    .done_pulse (done_pulse),
    .err_pulse  (err_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic offer(input logic [2:0] m, input logic [23:0] d);
    req_valid = m;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 3'b000;
  endtask

  task automatic wait_start(input int max, output bit found, output int n);
    found = 1'b0;
    n     = 0;
    while (!found && n < max) begin
      @(posedge clk); #1;
      n++;
      if (tx_start) found = 1'b1;
    end
    if (found) $display("launch grant=%0d byte=%h after %0d cycles", grant_id, tx_byte, n);
  endtask

  task automatic complete(input int k);
    repeat (k - 1) @(posedge clk);
    #1 tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic idle_wait();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    #12;
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got %b exp 111", req_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", tx_start); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", tx_byte); end
    checks++; if (busy !== 1'b0 || done_pulse !== 1'b0 || err_pulse !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_misc got busy=%b done=%b err=%b gid=%0d exp 0 0 0 0", busy, done_pulse, err_pulse, grant_id);
    end
    @(negedge clk) nRst = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_contention();
    bit found; int n;
    offer(3'b111, 24'h332211);
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL cont_ready got %b exp 000", req_ready); end
    wait_start(5, found, n);
    checks++; if (!found || n !== 1 || grant_id !== 2'd0 || tx_byte !== 8'h11) begin
      errors++; $display("FAIL cont_first got found=%b n=%0d gid=%0d byte=%h exp 1 1 0 11", found, n, grant_id, tx_byte);
    end
    complete(3);
    wait_start(20, found, n);
    checks++; if (!found || n !== 5 || grant_id !== 2'd1 || tx_byte !== 8'h22) begin
      errors++; $display("FAIL cont_second got found=%b n=%0d gid=%0d byte=%h exp 1 5 1 22", found, n, grant_id, tx_byte);
    end
    complete(3);
    wait_start(20, found, n);
    checks++; if (!found || n !== 5 || grant_id !== 2'd2 || tx_byte !== 8'h33) begin
      errors++; $display("FAIL cont_third got found=%b n=%0d gid=%0d byte=%h exp 1 5 2 33", found, n, grant_id, tx_byte);
    end
    complete(3);
  endtask

  task automatic test_single();
    bit found; int n;
    idle_wait();
    offer(3'b010, 24'h00A500);
    checks++; if (req_ready !== 3'b101) begin errors++; $display("FAIL single_ready got %b exp 101", req_ready); end
    wait_start(5, found, n);
    checks++; if (!found || n !== 1) begin errors++; $display("FAIL single_latency got found=%b n=%0d exp 1 1", found, n); end
    checks++; if (tx_byte !== 8'hA5 || grant_id !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_launch got byte=%h gid=%0d busy=%b exp A5 1 1", tx_byte, grant_id, busy);
    end
    repeat (9) @(posedge clk);
    #1;
    checks++; if (tx_start !== 1'b0 || tx_byte !== 8'hA5) begin
      errors++; $display("FAIL single_hold got start=%b byte=%h exp 0 A5", tx_start, tx_byte);
    end
    tx_done = 1'b1;
    #1;
    checks++; if (done_pulse !== 1'b1 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL single_done got done=%b err=%b exp 1 0", done_pulse, err_pulse);
    end
    @(posedge clk); #1;
    tx_done = 1'b0;
    checks++; if (req_ready !== 3'b111 || done_pulse !== 1'b0 || tx_byte !== 8'h00 || busy !== 1'b1) begin
      errors++; $display("FAIL single_after got ready=%b done=%b byte=%h busy=%b exp 111 0 00 1", req_ready, done_pulse, tx_byte, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_end got busy=%b exp 1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_fairness();
    bit found; int n;
    idle_wait();
    offer(3'b001, 24'h000044);
    wait_start(5, found, n);
    checks++; if (!found || grant_id !== 2'd0 || tx_byte !== 8'h44) begin
      errors++; $display("FAIL fair_first got found=%b gid=%0d byte=%h exp 1 0 44", found, grant_id, tx_byte);
    end
    offer(3'b100, 24'h550000);
    complete(3);
    offer(3'b001, 24'h000066);
    wait_start(20, found, n);
    checks++; if (!found || grant_id !== 2'd2 || tx_byte !== 8'h55) begin
      errors++; $display("FAIL fair_ch2 got found=%b gid=%0d byte=%h exp 1 2 55", found, grant_id, tx_byte);
    end
    complete(2);
    wait_start(20, found, n);
    checks++; if (!found || grant_id !== 2'd0 || tx_byte !== 8'h66) begin
      errors++; $display("FAIL fair_ch0 got found=%b gid=%0d byte=%h exp 1 0 66", found, grant_id, tx_byte);
    end
    complete(2);
  endtask

  task automatic test_timeout();
    bit found; int n;
    idle_wait();
    offer(3'b110, 24'h998800);
    wait_start(5, found, n);
    checks++; if (!found || n !== 1 || grant_id !== 2'd1 || tx_byte !== 8'h88) begin
      errors++; $display("FAIL to_launch got found=%b n=%0d gid=%0d byte=%h exp 1 1 1 88", found, n, grant_id, tx_byte);
    end
    repeat (19) @(posedge clk);
    #1;
    checks++; if (err_pulse !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL to_early got err=%b busy=%b exp 0 1", err_pulse, busy);
    end
    @(posedge clk); #1;
    checks++; if (err_pulse !== 1'b1 || done_pulse !== 1'b0 || grant_id !== 2'd1) begin
      errors++; $display("FAIL to_err got err=%b done=%b gid=%0d exp 1 0 1", err_pulse, done_pulse, grant_id);
    end
    @(posedge clk); #1;
    checks++; if (req_ready !== 3'b011 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL to_clear got ready=%b err=%b exp 011 0", req_ready, err_pulse);
    end
    wait_start(20, found, n);
    checks++; if (!found || n !== 5 || grant_id !== 2'd2 || tx_byte !== 8'h99) begin
      errors++; $display("FAIL to_next got found=%b n=%0d gid=%0d byte=%h exp 1 5 2 99", found, n, grant_id, tx_byte);
    end
    complete(2);
  endtask

  task automatic test_enable();
    bit found; int n;
    idle_wait();
    offer(3'b001, 24'h0000AA);
    wait_start(5, found, n);
    checks++; if (!found || grant_id !== 2'd0) begin
      errors++; $display("FAIL en_launch got found=%b gid=%0d exp 1 0", found, grant_id);
    end
    enable = 1'b0;
    offer(3'b100, 24'hBB0000);
    @(posedge clk);
    #1 tx_done = 1'b1;
    #1;
    checks++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL en_done got %b exp 1", done_pulse); end
    @(posedge clk); #1;
    tx_done = 1'b0;
    wait_start(15, found, n);
    checks++; if (found) begin errors++; $display("FAIL en_blocked got start after %0d cycles exp none", n); end
    checks++; if (busy !== 1'b0 || req_ready !== 3'b011) begin
      errors++; $display("FAIL en_idle got busy=%b ready=%b exp 0 011", busy, req_ready);
    end
    enable = 1'b1;
    wait_start(3, found, n);
    checks++; if (!found || n !== 1 || grant_id !== 2'd2 || tx_byte !== 8'hBB) begin
      errors++; $display("FAIL en_resume got found=%b n=%0d gid=%0d byte=%h exp 1 1 2 BB", found, n, grant_id, tx_byte);
    end
    complete(2);
  endtask

  task automatic test_reset_mid();
    bit found; int n; int pulses;
    idle_wait();
    offer(3'b011, 24'h00D2D1);
    wait_start(5, found, n);
    checks++; if (!found || grant_id !== 2'd0) begin
      errors++; $display("FAIL rst_launch got found=%b gid=%0d exp 1 0", found, grant_id);
    end
    repeat (2) @(posedge clk);
    #3 nRst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || tx_byte !== 8'h00) begin
      errors++; $display("FAIL rst_async got busy=%b start=%b byte=%h exp 0 0 00", busy, tx_start, tx_byte);
    end
    checks++; if (req_ready !== 3'b111 || done_pulse !== 1'b0 || err_pulse !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL rst_outs got ready=%b done=%b err=%b gid=%0d exp 111 0 0 0", req_ready, done_pulse, err_pulse, grant_id);
    end
    #2 nRst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (tx_start || done_pulse || err_pulse) pulses++;
    end
    checks++; if (pulses !== 0 || busy !== 1'b0 || req_ready !== 3'b111) begin
      errors++; $display("FAIL rst_quiet got pulses=%0d busy=%b ready=%b exp 0 0 111", pulses, busy, req_ready);
    end
  endtask

  initial begin
    nRst      = 1'b0;
    enable    = 1'b1;
    req_valid = 3'b000;
    req_data  = 24'h0;
    tx_done   = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_timeout();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
